ex_muldiv_iter: RTL and testbench
=================================

// Module: ex_muldiv_iter
// PURPOSE
// - Iterative multiply/divide unit beside the ex stage; replaces the single-cycle HI/LO multiplier path.
// - Computes MULT/MULTU/DIV/DIVU at 1 bit/cycle; optionally computes MADD/MSUB accumulate.
// - Drives busy_o to stall the pipeline; ex writes result_o to HI/LO when ready_o is high.
// PARAMETERS
// - DATA_W  32  operand width; result is 2*DATA_W, laid out {hi,lo}
// PORTS
// - clk        in   1         rising-edge clock
// - rst        in   1         synchronous, active-high reset
// - start_i    in   1         request; level, sampled only in IDLE
// - op_i       in   3         000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
// - opdata1_i  in   DATA_W    multiplicand / dividend
// - opdata2_i  in   DATA_W    multiplier / divisor
// - hi_i,lo_i  in   DATA_W    forwarded HI/LO accumulator, sampled at start
// - annul_i    in   1         flush; aborts any operation
// - result_o   out  2*DATA_W  {hi,lo}; DIV: hi=remainder, lo=quotient
// - ready_o    out  1         one-cycle pulse, result_o valid
// - busy_o     out  1         stall request (combinational)
// BEHAVIOUR
// - Reset: state=IDLE, result_o=0, ready_o=0, busy_o=0; reset mid-operation discards all work.
// - FSM states: IDLE, BYZERO, RUN, ACC, DONE.
// - IDLE with start_i && !annul_i: latch operands, op, and {hi_i,lo_i}; bit counter=0.
//   - Signed ops convert both operands to magnitude and record the sign flags.
//   - DIV/DIVU with opdata2_i==0 -> BYZERO; all other ops -> RUN.
// - RUN, one shift-add (mul) or restoring subtract (div) step per cycle.
//   - After DATA_W cycles: accumulate op -> ACC, else -> DONE.
// - ACC: one cycle, acc=acc+/-product, mod 2^(2*DATA_W); then -> DONE.
// - BYZERO: one cycle -> DONE with result 0.
// - Sign fix, applied when loading result_o:
//   - Product negated if operand signs differ.
//   - Quotient negated if signs differ; remainder takes the dividend sign.
//   - Unsigned ops: no fix.
// - DONE: ready_o=1 for exactly this cycle, then -> IDLE. start_i in DONE is ignored.
//   - Back-to-back: start seen in the following IDLE cycle is accepted.
// - result_o is registered on entry to DONE.
//   - Holds until the next accepted start, annul, or rst.
// - Latency (start cycle = t):
//   - MUL/DIV: ready at t+DATA_W+1.
//   - Accumulate: t+DATA_W+2.
//   - Divide-by-zero: t+2.
// - busy_o = (IDLE & start_i & !annul_i) | BYZERO | RUN | ACC; busy_o is 0 in DONE.
// - annul_i in any state: next state IDLE, result_o cleared, no ready_o. annul_i wins over start_i.
// - Overflow (e.g. most-negative / -1): two's-complement wrap, no trap.
// CONFIGURATION
// - MULDIV_MADD_EN defined: ops 1xx perform the accumulate path via ACC as above.
// - MULDIV_MADD_EN undefined:
//   - ops 1xx go IDLE -> DONE, ready at t+1, result 0.
//   - hi_i/lo_i are unused; the ACC state is not built.
// TESTING (DATA_W=32)
// - MULT -3 x 5 -> result 0xFFFFFFFF_FFFFFFF1.
//   - ready_o exactly at t+33; busy_o high t..t+32.
// - DIV -7/2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
//   - DIVU 7/2 -> hi=1, lo=3; both ready at t+33.
// - DIVU 5/0 -> ready at t+2, result 0; busy_o high t..t+1 only.
// - MULTU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE_00000001.
//   - Second start in the cycle after ready is accepted and completes normally.
// - annul_i at t+10 of a DIV -> IDLE at t+11, no ready_o, result 0.
//   - rst mid-RUN gives the same outcome.
// - MADD with MULDIV_MADD_EN, HI/LO=0x0_00000001, -1 x 2 -> 0xFFFFFFFF_FFFFFFFF at t+34.
//   - Without the macro: ready at t+1, result 0.

Source files
------------

// File: rtl/ex_muldiv_iter.sv
// Iterative 1-bit/cycle multiply/divide unit for HI/LO; result laid out {hi,lo}.
// Define MULDIV_MADD_EN to build the MADD/MSUB accumulate path (ACC state).
module ex_muldiv_iter #(
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [2:0]            op_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic [DATA_W-1:0]     hi_i,
   input  logic [DATA_W-1:0]     lo_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o,
   output logic                  busy_o
);

   localparam int unsigned CW = $clog2(DATA_W) + 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BYZERO = 3'd1,
      RUN    = 3'd2,
      DONE   = 3'd3
`ifdef MULDIV_MADD_EN
      , ACC  = 3'd4
`endif
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_W-1:0]     a_q, a_d;
   logic [2*DATA_W-1:0]   p_q, p_d;
   logic [2*DATA_W-1:0]   res_q, res_d;
   logic                  div_q, div_d;
   logic                  neg_q, neg_d;
   logic                  s1_q, s1_d;
`ifdef MULDIV_MADD_EN
   logic [2*DATA_W-1:0]   acc_q, acc_d;
   logic                  madd_q, madd_d;
   logic                  sub_q, sub_d;
`else
   logic                  unused_acc_in;
   assign unused_acc_in = ^{hi_i, lo_i};
`endif

   logic [DATA_W-1:0]     p_hi, p_lo, step_hi, step_lo, fix_hi, fix_lo;
   logic [DATA_W:0]       mul_sum, div_shift, div_diff;
   logic                  div_ge;
   logic [2*DATA_W-1:0]   step, step_neg, fixed;
   logic                  sgn, s1, s2;
   logic [DATA_W-1:0]     m1, m2;

   // Shared datapath: p holds {partial product} for mul, {remainder, quotient} for div.
   always_comb begin
      p_hi      = p_q[2*DATA_W-1:DATA_W];
      p_lo      = p_q[DATA_W-1:0];
      mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_q} : '0);
      div_shift = {p_hi, p_lo[DATA_W-1]};
      div_diff  = div_shift - {1'b0, a_q};
      div_ge    = (div_shift >= {1'b0, a_q});
      if (div_q) begin
         step_hi = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
         step_lo = {p_lo[DATA_W-2:0], div_ge};
      end else begin
         step_hi = mul_sum[DATA_W:1];
         step_lo = {mul_sum[0], p_lo[DATA_W-1:1]};
      end
      step     = {step_hi, step_lo};
      step_neg = -step;
      fix_hi   = s1_q  ? -step_hi : step_hi;
      fix_lo   = neg_q ? -step_lo : step_lo;
      if (div_q) fixed = {fix_hi, fix_lo};
      else       fixed = neg_q ? step_neg : step;
   end

   always_comb begin
      sgn = ~op_i[0];
      s1  = sgn & opdata1_i[DATA_W-1];
      s2  = sgn & opdata2_i[DATA_W-1];
      m1  = s1 ? -opdata1_i : opdata1_i;
      m2  = s2 ? -opdata2_i : opdata2_i;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      p_d     = p_q;
      res_d   = res_q;
      div_d   = div_q;
      neg_d   = neg_q;
      s1_d    = s1_q;
`ifdef MULDIV_MADD_EN
      acc_d   = acc_q;
      madd_d  = madd_q;
      sub_d   = sub_q;
`endif
      ready_o = 1'b0;
      busy_o  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i && !annul_i) begin
               busy_o = 1'b1;
               res_d  = '0;
               cnt_d  = '0;
               s1_d   = s1;
               neg_d  = s1 ^ s2;
               div_d  = (op_i[2:1] == 2'b01);
               if (op_i[2:1] == 2'b01) begin
                  a_d = m2;
                  p_d = {{DATA_W{1'b0}}, m1};
               end else begin
                  a_d = m1;
                  p_d = {{DATA_W{1'b0}}, m2};
               end
               if (op_i[2]) begin
`ifdef MULDIV_MADD_EN
                  acc_d   = {hi_i, lo_i};
                  madd_d  = 1'b1;
                  sub_d   = op_i[1];
                  state_d = RUN;
`else
                  state_d = DONE;
`endif
               end else begin
`ifdef MULDIV_MADD_EN
                  madd_d = 1'b0;
`endif
                  if (op_i[1] && opdata2_i == '0) state_d = BYZERO;
                  else                            state_d = RUN;
               end
            end
         end
         BYZERO: begin
            busy_o  = 1'b1;
            res_d   = '0;
            state_d = DONE;
         end
         RUN: begin
            busy_o = 1'b1;
            p_d    = step;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
`ifdef MULDIV_MADD_EN
               if (madd_q) begin
                  p_d     = fixed;
                  state_d = ACC;
               end else begin
                  res_d   = fixed;
                  state_d = DONE;
               end
`else
               res_d   = fixed;
               state_d = DONE;
`endif
            end
         end
`ifdef MULDIV_MADD_EN
         ACC: begin
            busy_o  = 1'b1;
            res_d   = sub_q ? (acc_q - p_q) : (acc_q + p_q);
            state_d = DONE;
         end
`endif
         DONE: begin
            ready_o = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Flush overrides everything, including the DONE pulse.
      if (annul_i) begin
         state_d = IDLE;
         res_d   = '0;
         ready_o = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         p_q     <= '0;
         res_q   <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         s1_q    <= 1'b0;
`ifdef MULDIV_MADD_EN
         acc_q   <= '0;
         madd_q  <= 1'b0;
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         p_q     <= p_d;
         res_q   <= res_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         s1_q    <= s1_d;
`ifdef MULDIV_MADD_EN
         acc_q   <= acc_d;
         madd_q  <= madd_d;
         sub_q   <= sub_d;
`endif
      end
   end

   assign result_o = res_q;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Scoreboard bench for ex_muldiv_iter: directed ops push {result, ready cycle}; a monitor checks.
module tb_ex_muldiv_iter;

   typedef struct {
      logic [63:0] res;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [2:0]  op_i = '0;
   logic [31:0] opdata1_i = '0, opdata2_i = '0, hi_i = '0, lo_i = '0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o, busy_o;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int unsigned n_chk = 0, n_fail = 0;
   int unsigned win_lo = 1, win_hi = 0;
   logic        mon_en = 1'b0;
   logic        hold_chk = 1'b0;
   logic [63:0] hold_val = '0;

   ex_muldiv_iter #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
      .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hi_i(hi_i), .lo_i(lo_i),
      .annul_i(annul_i), .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: busy profile every cycle, results and ready timing from the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy", {63'd0, busy_o}, {63'd0, (cyc >= win_lo && cyc <= win_hi)});
         if (hold_chk) begin
            chk("result_hold", result_o, hold_val);
            hold_chk = 1'b0;
         end
         if (ready_o === 1'b1) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_ready: got ready_o=1, expected 0 (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result", result_o, e.res);
               chk("ready_cycle", 64'(cyc), 64'(e.cyc));
               hold_chk = 1'b1;
               hold_val = e.res;
            end
         end
      end
   end

   // Called right at a posedge; returns at the posedge after ready (DUT back in IDLE).
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo,
                        input logic [63:0] exp, input int unsigned lat);
      exp_t e;
      #1;
      start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b; hi_i = hi; lo_i = lo;
      win_lo = cyc; win_hi = cyc + lat - 1;
      e.res = exp; e.cyc = cyc + lat;
      sb.push_back(e);
      @(posedge clk);
      #1 start_i = 1'b0;
      for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL ready_timeout: got no ready_o, expected one for op %b", op);
         sb.delete();
         @(posedge clk);
      end
   endtask

   // Start a DIV, then kill it at t+10 with annul_i (use_rst=0) or rst (use_rst=1).
   task automatic do_kill(input logic use_rst);
      int unsigned t;
      #1;
      start_i = 1'b1; op_i = 3'b010; opdata1_i = 32'd1000; opdata2_i = 32'd3;
      t = cyc;
      win_lo = t; win_hi = t + 10;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      if (use_rst) rst = 1'b1;
      else         annul_i = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; annul_i = 1'b0;
      chk(use_rst ? "rst_result" : "annul_result", result_o, 64'd0);
      chk(use_rst ? "rst_ready" : "annul_ready", {63'd0, ready_o}, 64'd0);
      @(posedge clk);
   endtask

   initial begin
      fork
         begin
            #2000000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("reset_result", result_o, 64'd0);
      chk("reset_ready", {63'd0, ready_o}, 64'd0);
      @(posedge clk);

      do_op(3'b000, 32'hFFFF_FFFD, 32'd5, '0, '0, 64'hFFFFFFFF_FFFFFFF1, 33);        // MULT -3*5
      do_op(3'b010, 32'hFFFF_FFF9, 32'd2, '0, '0, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33); // DIV -7/2
      do_op(3'b011, 32'd7, 32'd2, '0, '0, {32'd1, 32'd3}, 33);                       // DIVU 7/2
      do_op(3'b011, 32'd5, 32'd0, '0, '0, 64'd0, 2);                                 // DIVU 5/0
      do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0, 64'hFFFFFFFE_00000001, 33);
      do_op(3'b000, 32'd6, 32'hFFFF_FFF9, '0, '0, 64'hFFFFFFFF_FFFFFFD6, 33);        // back-to-back
      do_op(3'b010, 32'd100, 32'hFFFF_FFF9, '0, '0, {32'd2, 32'hFFFFFFF2}, 33);      // DIV 100/-7
      do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, {32'd0, 32'h80000000}, 33);
      do_op(3'b010, 32'd9, 32'd0, '0, '0, 64'd0, 2);                                 // DIV by zero

      do_kill(1'b0);
      do_op(3'b011, 32'd100, 32'd7, '0, '0, {32'd2, 32'd14}, 33);
      do_kill(1'b1);
      do_op(3'b001, 32'd3, 32'd4, '0, '0, 64'd12, 33);

`ifdef MULDIV_MADD_EN
      do_op(3'b100, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 34);  // MADD
      do_op(3'b111, 32'd3, 32'd4, 32'd0, 32'h10, 64'd4, 34);                          // MSUBU
`else
      do_op(3'b100, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1, 64'd0, 1);
      do_op(3'b111, 32'd3, 32'd4, 32'd0, 32'h10, 64'd0, 1);
`endif
      do_op(3'b000, 32'd7, 32'd7, '0, '0, 64'd49, 33);

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
